// File: rtl/byte_word_packer.sv
// -----------------------------------------------------------------------------
// byte_word_packer
//
// Packs a stream of bytes into 32-bit words. Four accepted bytes form a full
// word; a flush pulse emits whatever partial word is in progress, zero-padded
// in the lanes that were never filled. A one-entry output register decouples
// the packer from the consumer and allows back-to-back words with no bubble.
//
// Parameters
//   BIG_ENDIAN_IN  1: first byte lands in out_data[31:24]
//                  0: first byte lands in out_data[7:0]
//
// Ports
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   in_data holds a byte
//   in_data    in   8   stream byte
//   in_ready   out  1   byte taken on an edge with in_valid && in_ready
//   flush      in   1   single-cycle pulse: emit partial word
//   out_valid  out  1   out_data / out_bytes hold a word
//   out_data   out  32  assembled word
//   out_bytes  out  3   number of valid bytes in out_data (1..4)
//   out_ready  in   1   word taken on an edge with out_valid && out_ready
//   words_out  out  16  wrapping count of output handshakes
//
// State table
//   state          | meaning
//   ST_EMPTY       | no bytes collected, cnt = 0
//   ST_FILL        | 1..3 bytes collected in the accumulator
//   ST_FLUSH_PEND  | flush seen while the output register was full; the
//                  | partial word waits for the current word to drain
// -----------------------------------------------------------------------------
module byte_word_packer #(
    parameter bit BIG_ENDIAN_IN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        flush,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [2:0]  out_bytes,
    input  logic        out_ready,
    output logic [15:0] words_out
);

    typedef enum logic [1:0] {
        ST_EMPTY      = 2'd0,
        ST_FILL       = 2'd1,
        ST_FLUSH_PEND = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] acc_q, acc_d;

    logic        out_valid_q, out_valid_d;
    logic [31:0] out_data_q, out_data_d;
    logic [2:0]  out_bytes_q, out_bytes_d;
    logic [15:0] words_q, words_d;

    // Held low through reset and set on the first clock edge afterwards, so
    // in_ready stays 0 while reset is asserted and rises one edge later.
    logic        rdy_en_q;

    logic        out_free;
    logic        handshake;
    logic        accept;
    logic [31:0] acc_new;
    logic [1:0]  cnt_inc;
    logic [2:0]  bytes_inc;

    logic        load;
    logic [31:0] load_data;
    logic [2:0]  load_bytes;

    // Place byte number idx (arrival order) into its lane of the accumulator.
    // Unfilled lanes are always zero because the accumulator clears whenever
    // cnt returns to 0, so an OR is sufficient.
    function automatic logic [31:0] lane_insert(
        input logic [31:0] acc,
        input logic [1:0]  idx,
        input logic [7:0]  b
    );
        logic [4:0] sh;
        if (BIG_ENDIAN_IN) begin
            sh = {~idx, 3'b000};
        end else begin
            sh = {idx, 3'b000};
        end
        return acc | (32'(b) << sh);
    endfunction

    // The output register can take a new word when it is empty or when its
    // current word is being consumed on this same edge.
    assign out_free  = !out_valid_q || out_ready;
    assign handshake = out_valid_q && out_ready;

    assign in_ready  = rdy_en_q && (state_q != ST_FLUSH_PEND) &&
                       ((cnt_q != 2'd3) || out_free);
    assign accept    = in_valid && in_ready;

    assign acc_new   = lane_insert(acc_q, cnt_q, in_data);
    assign cnt_inc   = cnt_q + 2'd1;
    assign bytes_inc = {1'b0, cnt_q} + 3'd1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        load       = 1'b0;
        load_data  = acc_q;
        load_bytes = {1'b0, cnt_q};

        unique case (state_q)
            ST_EMPTY, ST_FILL: begin
                if (accept) begin
                    if (cnt_q == 2'd3) begin
                        // Fourth byte completes the word; any flush on this
                        // cycle is absorbed by the full-word emit.
                        load       = 1'b1;
                        load_data  = acc_new;
                        load_bytes = 3'd4;
                        cnt_d      = 2'd0;
                        acc_d      = '0;
                        state_d    = ST_EMPTY;
                    end else if (flush) begin
                        // The byte arriving with the flush is part of the
                        // partial word.
                        if (out_free) begin
                            load       = 1'b1;
                            load_data  = acc_new;
                            load_bytes = bytes_inc;
                            cnt_d      = 2'd0;
                            acc_d      = '0;
                            state_d    = ST_EMPTY;
                        end else begin
                            acc_d   = acc_new;
                            cnt_d   = cnt_inc;
                            state_d = ST_FLUSH_PEND;
                        end
                    end else begin
                        acc_d   = acc_new;
                        cnt_d   = cnt_inc;
                        state_d = ST_FILL;
                    end
                end else if (flush && (cnt_q != 2'd0)) begin
                    if (out_free) begin
                        load       = 1'b1;
                        load_data  = acc_q;
                        load_bytes = {1'b0, cnt_q};
                        cnt_d      = 2'd0;
                        acc_d      = '0;
                        state_d    = ST_EMPTY;
                    end else begin
                        state_d = ST_FLUSH_PEND;
                    end
                end
            end

            ST_FLUSH_PEND: begin
                // Further flushes are ignored; the partial word moves into the
                // output register on the edge the held word is consumed.
                if (handshake) begin
                    load       = 1'b1;
                    load_data  = acc_q;
                    load_bytes = {1'b0, cnt_q};
                    cnt_d      = 2'd0;
                    acc_d      = '0;
                    state_d    = ST_EMPTY;
                end
            end

            default: begin
                cnt_d   = 2'd0;
                acc_d   = '0;
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_bytes_d = out_bytes_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = load_data;
            out_bytes_d = load_bytes;
        end
    end

    assign words_d = words_q + {15'd0, handshake};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            cnt_q       <= 2'd0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_bytes_q <= 3'd0;
            words_q     <= 16'd0;
            rdy_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_bytes_q <= out_bytes_d;
            words_q     <= words_d;
            rdy_en_q    <= 1'b1;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_bytes = out_bytes_q;
    assign words_out = words_q;

endmodule

// File: tb/tb_byte_word_packer.sv
module tb_byte_word_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        flush;
    logic        out_ready;

    logic        in_ready_be, out_valid_be;
    logic [31:0] out_data_be;
    logic [2:0]  out_bytes_be;
    logic [15:0] words_be;

    logic        in_ready_le, out_valid_le;
    logic [31:0] out_data_le;
    logic [2:0]  out_bytes_le;
    logic [15:0] words_le;

    typedef struct packed {
        logic [31:0] be;
        logic [31:0] le;
        logic [2:0]  nb;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    byte_word_packer #(.BIG_ENDIAN_IN(1'b1)) dut_be (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_be),
        .flush(flush),
        .out_valid(out_valid_be), .out_data(out_data_be), .out_bytes(out_bytes_be),
        .out_ready(out_ready), .words_out(words_be)
    );

    byte_word_packer #(.BIG_ENDIAN_IN(1'b0)) dut_le (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_le),
        .flush(flush),
        .out_valid(out_valid_le), .out_data(out_data_le), .out_bytes(out_bytes_le),
        .out_ready(out_ready), .words_out(words_le)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void expect_word(input logic [31:0] be, input logic [31:0] le,
                                        input logic [2:0] nb);
        exp_t e;
        e.be = be;
        e.le = le;
        e.nb = nb;
        sb.push_back(e);
    endfunction

    // Monitor: every output handshake pops and checks the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && out_valid_be === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %h expected no word", out_data_be);
            end else begin
                e = sb.pop_front();
                check("word_be",  out_data_be, e.be);
                check("word_le",  out_data_le, e.le);
                check("bytes_be", {29'd0, out_bytes_be}, {29'd0, e.nb});
                check("bytes_le", {29'd0, out_bytes_le}, {29'd0, e.nb});
                check("valid_le", {31'd0, out_valid_le}, 32'd1);
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic fl);
        int n;
        in_valid = 1'b1;
        in_data  = b;
        flush    = fl;
        n = 0;
        @(negedge clk);
        while (in_ready_be !== 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready_be);
        end
        sync();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        sync();
        flush = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out_valid"}, {31'd0, out_valid_be}, 32'd0);
        check({tag, "_out_data"},  out_data_be, 32'd0);
        check({tag, "_out_bytes"}, {29'd0, out_bytes_be}, 32'd0);
        check({tag, "_in_ready"},  {31'd0, in_ready_be}, 32'd0);
        check({tag, "_words"},     {16'd0, words_be}, 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Reset values, then in_ready rises on the first edge after release.
        #12;
        check_all_zero("reset");
        #5 rst_n = 1'b1;
        @(negedge clk);
        check("ready_before_edge", {31'd0, in_ready_be}, 32'd0);
        sync();
        check("ready_after_edge", {31'd0, in_ready_be}, 32'd1);

        // Full word, both endiannesses, one-cycle latency.
        out_ready = 1'b1;
        send(8'h12, 1'b0);
        send(8'h34, 1'b0);
        send(8'h56, 1'b0);
        check("no_early_valid", {31'd0, out_valid_be}, 32'd0);
        expect_word(32'h12345678, 32'h78563412, 3'd4);
        send(8'h78, 1'b0);
        @(negedge clk);
        check("latency_valid", {31'd0, out_valid_be}, 32'd1);
        @(negedge clk);
        check("words_1", {16'd0, words_be}, 32'd1);

        // Partial word by flush, then flush with nothing collected.
        sync();
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        expect_word(32'hAABB0000, 32'h0000BBAA, 3'd2);
        pulse_flush();
        @(negedge clk);
        @(negedge clk);
        check("words_2", {16'd0, words_be}, 32'd2);
        sync();
        pulse_flush();
        repeat (3) @(negedge clk);
        check("empty_flush_no_valid", {31'd0, out_valid_be}, 32'd0);
        check("empty_flush_words", {16'd0, words_be}, 32'd2);

        // Flush together with a byte: partial includes it; on the 4th byte
        // the flush is consumed by the full word.
        sync();
        send(8'hCC, 1'b0);
        expect_word(32'hCCDD0000, 32'h0000DDCC, 3'd2);
        send(8'hDD, 1'b1);
        send(8'h9A, 1'b0);
        send(8'hBC, 1'b0);
        send(8'hDE, 1'b0);
        expect_word(32'h9ABCDEF0, 32'hF0DEBC9A, 3'd4);
        send(8'hF0, 1'b1);
        repeat (4) @(negedge clk);
        check("flush4_words", {16'd0, words_be}, 32'd4);
        check("flush4_no_extra", {31'd0, out_valid_be}, 32'd0);

        // Backpressure: in_ready drops at cnt=3, back-to-back on release.
        sync();
        out_ready = 1'b0;
        expect_word(32'h11223344, 32'h44332211, 3'd4);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        send(8'h77, 1'b0);
        @(negedge clk);
        check("ready_low_cnt3", {31'd0, in_ready_be}, 32'd0);
        check("held_data", out_data_be, 32'h11223344);
        sync();
        in_valid  = 1'b1;
        in_data   = 8'h88;
        out_ready = 1'b1;
        expect_word(32'h55667788, 32'h88776655, 3'd4);
        @(negedge clk);
        check("ready_with_out_ready", {31'd0, in_ready_be}, 32'd1);
        sync();
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_valid", {31'd0, out_valid_be}, 32'd1);
        check("b2b_data", out_data_be, 32'h55667788);
        @(negedge clk);
        check("words_6", {16'd0, words_be}, 32'd6);

        // Flush while the output register is held: pending partial word.
        sync();
        out_ready = 1'b0;
        expect_word(32'hA1A2A3A4, 32'hA4A3A2A1, 3'd4);
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b0);
        send(8'hA3, 1'b0);
        send(8'hA4, 1'b0);
        send(8'hB1, 1'b0);
        send(8'hB2, 1'b0);
        pulse_flush();
        @(negedge clk);
        check("ready_low_flush_pend", {31'd0, in_ready_be}, 32'd0);
        sync();
        pulse_flush();
        expect_word(32'hB1B20000, 32'h0000B2B1, 3'd2);
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("pend_valid", {31'd0, out_valid_be}, 32'd1);
        check("pend_bytes", {29'd0, out_bytes_be}, 32'd2);
        @(negedge clk);
        check("words_8", {16'd0, words_be}, 32'd8);
        check("ready_after_pend", {31'd0, in_ready_be}, 32'd1);

        // Reset with a held word and a partial word in flight.
        sync();
        out_ready = 1'b0;
        send(8'hC1, 1'b0);
        send(8'hC2, 1'b0);
        send(8'hC3, 1'b0);
        send(8'hC4, 1'b0);
        send(8'hD1, 1'b0);
        send(8'hD2, 1'b0);
        check("pre_reset_valid", {31'd0, out_valid_be}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        sync();
        rst_n = 1'b1;
        out_ready = 1'b1;
        expect_word(32'h01020304, 32'h04030201, 3'd4);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("post_reset_words", {16'd0, words_be}, 32'd1);

        // Drive words_out to 0xFFFF with one-byte flushed words, then wrap.
        sync();
        for (int i = 0; i < 65534; i++) begin
            in_valid = 1'b1;
            flush    = 1'b1;
            in_data  = i[7:0];
            expect_word({in_data, 24'h000000}, {24'h000000, in_data}, 3'd1);
            sync();
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("words_ffff", {16'd0, words_be}, 32'h0000FFFF);
        sync();
        expect_word(32'h5A5B5C5D, 32'h5D5C5B5A, 3'd4);
        send(8'h5A, 1'b0);
        send(8'h5B, 1'b0);
        send(8'h5C, 1'b0);
        send(8'h5D, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("words_wrap_be", {16'd0, words_be}, 32'd0);
        check("words_wrap_le", {16'd0, words_le}, 32'd0);

        for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/byte_word_packer.md
BYTE_WORD_PACKER -- requirements
Module: byte_word_packer

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low (name the clock and reset ports as the codebase does; the polarity and synchronicity here are fixed): ports clk and rst_n.
REQ-002 Parameter BIG_ENDIAN_IN, default 1, SHALL select byte placement: 1 = first byte received lands in out_data[31:24]; 0 = first byte received lands in out_data[7:0].
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  in_data holds a valid byte.
REQ-006 in_data  input  8  stream byte.
REQ-007 in_ready  output  1  byte accepted on a clk edge where in_valid && in_ready.
REQ-008 flush  input  1  single-cycle pulse; emit any partial word zero-padded.
REQ-009 out_valid  output  1  out_data/out_bytes hold a word.
REQ-010 out_data  output  32  assembled word.
REQ-011 out_bytes  output  3  count of valid bytes in out_data, 1..4.
REQ-012 out_ready  input  1  word consumed on a clk edge where out_valid && out_ready.
REQ-013 words_out  output  16  count of completed output handshakes.

Function
REQ-014 Internals SHALL be a 32-bit accumulator, a 2-bit byte index cnt (0..3) and a one-entry output register.
REQ-015 States SHALL be EMPTY (cnt=0), FILL (cnt=1..3) and FLUSH_PEND; EMPTY->FILL on an accepted byte; FILL->EMPTY on an accepted 4th byte; FILL->FLUSH_PEND on flush while the output register is occupied and not draining.
REQ-016 Byte k (0..3, arrival order) SHALL be written to bits [31-8k:24-8k] when BIG_ENDIAN_IN=1, and to bits [8k+7:8k] when BIG_ENDIAN_IN=0.
REQ-017 When the 4th byte is accepted, the word SHALL load into the output register on the same edge, with out_valid=1 and out_bytes=4 from the next cycle, for a latency of 1 cycle from acceptance.
REQ-018 in_ready SHALL be 1 when cnt<3, or when the output register is empty, or when out_ready=1 in the same cycle; otherwise 0. It SHALL be 0 in FLUSH_PEND.
REQ-019 out_valid, out_data and out_bytes SHALL hold stable until the out_valid && out_ready handshake. A new word may load on the same edge as the handshake, so back-to-back words are possible with no bubble.
REQ-020 On flush with cnt>0 and the output register free or draining: emit the partial word, with unreceived byte lanes = 0x00 and out_bytes=cnt, then clear cnt.
REQ-021 On flush with cnt=0 (EMPTY): no output and no state change.
REQ-022 On flush together with an accepted byte: the byte SHALL be included first. If that byte is the 4th, the normal full-word emit applies and the flush is consumed; otherwise a partial word is emitted with out_bytes=cnt+1.
REQ-023 In FLUSH_PEND, the partial word SHALL load on the edge of the pending output handshake; the next state is EMPTY.
REQ-024 A flush arriving while already in FLUSH_PEND SHALL be ignored.
REQ-025 words_out SHALL increment by 1 per output handshake and wrap 0xFFFF->0x0000.
REQ-026 The accumulator SHALL clear to zero whenever cnt returns to 0.

Reset
REQ-027 While rst_n=0: out_valid=0, out_data=0, out_bytes=0, in_ready=0, words_out=0, cnt=0, accumulator=0, state EMPTY.
REQ-028 After rst_n deasserts, in_ready=1 from the first clk edge; a partial word present at reset assertion SHALL be discarded.

Verification
REQ-029 BIG_ENDIAN_IN=1, bytes 12,34,56,78 with out_ready=1 -> out_data=0x12345678, out_bytes=4, out_valid one cycle after the 4th byte, words_out=1.
REQ-030 BIG_ENDIAN_IN=0, same bytes -> out_data=0x78563412, out_bytes=4.
REQ-031 BIG_ENDIAN_IN=1, bytes AA,BB then flush -> out_data=0xAABB0000, out_bytes=2; a subsequent flush with cnt=0 produces no output.
REQ-032 out_ready=0 with one word held, 3 more bytes sent -> in_ready=0 when cnt=3; raising out_ready with the 4th byte -> the handshake and the new word load on the same edge, back-to-back.
REQ-033 words_out preset by 65535 handshakes, then one more word -> words_out=0x0000.
REQ-034 rst_n pulsed low with cnt=2 and out_valid=1 -> all outputs 0 immediately; next 4 bytes 01,02,03,04 -> 0x01020304.
